// File: rtl/mem_access_stage_if.sv
// Data-RAM bus between the memory stage (master) and a 32-bit synchronous RAM (slave).
// mem_q is valid the cycle after mem_addr is driven.
interface mem_access_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport master (output mem_addr, output mem_wdata, output mem_wren, input mem_q);
  modport slave  (input mem_addr, input mem_wdata, input mem_wren, output mem_q);
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the vector pipeline: sequences scalar and 4-lane vector loads/stores
// over the data RAM, stalls empipe during multi-beat accesses and registers the M->W payload.
module mem_access_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      regw_M,
  input  logic                      memw_M,
  input  logic                      regmem_M,
  input  logic                      vect_M,
  input  logic [3:0]                regScr_M,
  input  logic [DATA_W*LANES-1:0]   ALUrslt_M,
  input  logic [DATA_W*LANES-1:0]   address_M,
  output logic                      stall_M,
  mem_access_stage_if.master        mem,
  output logic                      regw_W,
  output logic                      regmem_W,
  output logic                      vect_W,
  output logic [3:0]                regScr_W,
  output logic [DATA_W*LANES-1:0]   ALUrslt_W,
  output logic [DATA_W*LANES-1:0]   memdata_W
);
  localparam int VW    = DATA_W * LANES;
  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, LWAIT, VLD, VST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  prev_cnt;
  logic [VW-1:0]     lane_buf;
  logic [ADDR_W-1:0] base;
  logic              is_load;
  logic              unused_addr_bits;

  assign base             = address_M[ADDR_W-1:0];
  assign unused_addr_bits = ^address_M[VW-1:ADDR_W];
  assign is_load          = regmem_M & ~memw_M;
  assign prev_cnt         = cnt - CNT_W'(1);

  // Beat cnt addresses base+cnt (wrapping); in IDLE cnt is 0 so beat 0 goes to base.
  always_comb begin
    mem.mem_addr  = base + ADDR_W'(cnt);
    mem.mem_wdata = ALUrslt_M[DATA_W*cnt +: DATA_W];
    mem.mem_wren  = 1'b0;
    stall_M       = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          mem.mem_wren = memw_M;
          stall_M      = (memw_M & vect_M) | is_load;
        end
        VLD:     stall_M = 1'b1;
        VST: begin
          mem.mem_wren = 1'b1;
          stall_M      = (cnt != LAST);
        end
        default: stall_M = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lane_buf  <= '0;
      regw_W    <= 1'b0;
      regmem_W  <= 1'b0;
      vect_W    <= 1'b0;
      regScr_W  <= '0;
      ALUrslt_W <= '0;
      memdata_W <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memw_M && vect_M) begin
            state <= VST;
            cnt   <= CNT_W'(1);
          end else if (is_load) begin
            state <= vect_M ? VLD : LWAIT;
            cnt   <= vect_M ? CNT_W'(1) : '0;
          end
        end
        VLD: begin
          lane_buf[DATA_W*prev_cnt +: DATA_W] <= mem.mem_q;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= LWAIT;
        end
        VST: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // A stalled cycle hands writeback a bubble; payload fields simply hold.
      if (stall_M) begin
        regw_W   <= 1'b0;
        regmem_W <= 1'b0;
        vect_W   <= 1'b0;
      end else begin
        regw_W    <= regw_M;
        regmem_W  <= regmem_M;
        vect_W    <= vect_M;
        regScr_W  <= regScr_M;
        ALUrslt_W <= ALUrslt_M;
        if (state == LWAIT)
          memdata_W <= vect_M ? {mem.mem_q, lane_buf[VW-DATA_W-1:0]}
                              : {{(VW-DATA_W){1'b0}}, mem.mem_q};
      end
    end
  end
endmodule
